// File: rtl/iommu_ctx_cache.sv
// iommu_ctx_cache: fully associative DDTC/PDTC context cache with a registered lookup,
// invalid-first/PLRU replacement, scoped flushes and an occupancy counter.
module iommu_ctx_cache #(
    parameter int ENTRIES          = 8,
    parameter int DEVICE_ID_WIDTH  = 24,
    parameter int PROCESS_ID_WIDTH = 20,
    parameter bit PID_EN           = 1'b1,
    parameter int CONTENT_WIDTH    = 512
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          flush_i,
    input  logic                          flush_dv_i,
    input  logic                          flush_pv_i,
    input  logic [DEVICE_ID_WIDTH-1:0]    flush_did_i,
    input  logic [PROCESS_ID_WIDTH-1:0]   flush_pid_i,
    input  logic                          update_i,
    input  logic [DEVICE_ID_WIDTH-1:0]    up_did_i,
    input  logic [PROCESS_ID_WIDTH-1:0]   up_pid_i,
    input  logic [CONTENT_WIDTH-1:0]      up_content_i,
    input  logic                          lookup_i,
    input  logic [DEVICE_ID_WIDTH-1:0]    lu_did_i,
    input  logic [PROCESS_ID_WIDTH-1:0]   lu_pid_i,
    output logic                          lu_valid_o,
    output logic                          lu_hit_o,
    output logic [CONTENT_WIDTH-1:0]      lu_content_o,
    output logic [$clog2(ENTRIES):0]      occ_o
);
    localparam int LOG   = $clog2(ENTRIES);
    localparam int OW    = LOG + 1;
    localparam int NODES = ENTRIES - 1;

    logic [ENTRIES-1:0]          valid_q, valid_d;
    logic [DEVICE_ID_WIDTH-1:0]  did_q [ENTRIES];
    logic [DEVICE_ID_WIDTH-1:0]  did_d [ENTRIES];
    logic [PROCESS_ID_WIDTH-1:0] pid_q [ENTRIES];
    logic [PROCESS_ID_WIDTH-1:0] pid_d [ENTRIES];
    logic [CONTENT_WIDTH-1:0]    content_q [ENTRIES];
    logic [CONTENT_WIDTH-1:0]    content_d [ENTRIES];
    logic [NODES-1:0]            plru_q, plru_d;
    logic                        lu_valid_q, lu_valid_d;
    logic                        lu_hit_q, lu_hit_d;
    logic [CONTENT_WIDTH-1:0]    lu_content_q, lu_content_d;
    logic [OW-1:0]               occ_q, occ_d;

    logic [ENTRIES-1:0] lu_match, up_match, flush_mask;
    logic [LOG-1:0]     lu_idx, up_idx, free_idx, wr_idx;

    // Point every node on idx's root-to-leaf path away from idx.
    function automatic logic [NODES-1:0] plru_touch(input logic [NODES-1:0] t, input logic [LOG-1:0] idx);
        int node;
        node = 0;
        for (int d = 0; d < LOG; d++) begin
            t[node] = ~idx[LOG-1-d];
            node = 2 * node + (idx[LOG-1-d] ? 2 : 1);
        end
        return t;
    endfunction

    function automatic logic [LOG-1:0] plru_victim(input logic [NODES-1:0] t);
        int node;
        logic [LOG-1:0] v;
        node = 0;
        v = '0;
        for (int d = 0; d < LOG; d++) begin
            v[LOG-1-d] = t[node];
            node = 2 * node + (t[node] ? 2 : 1);
        end
        return v;
    endfunction

    always_comb begin
        lu_idx   = '0;
        up_idx   = '0;
        free_idx = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            lu_match[i]   = valid_q[i] && did_q[i] == lu_did_i && (!PID_EN || pid_q[i] == lu_pid_i);
            up_match[i]   = valid_q[i] && did_q[i] == up_did_i && (!PID_EN || pid_q[i] == up_pid_i);
            flush_mask[i] = flush_i && valid_q[i] && (!flush_dv_i || (did_q[i] == flush_did_i &&
                            (!PID_EN || !flush_pv_i || pid_q[i] == flush_pid_i)));
            if (lu_match[i]) lu_idx = LOG'(i);
            if (up_match[i]) up_idx = LOG'(i);
        end
        for (int i = ENTRIES - 1; i >= 0; i--)
            if (!valid_q[i]) free_idx = LOG'(i);
    end

    always_comb begin
        valid_d      = valid_q & ~flush_mask;
        did_d        = did_q;
        pid_d        = pid_q;
        content_d    = content_q;
        plru_d       = plru_q;
        lu_valid_d   = lookup_i;
        // A same-cycle flush of the matched entry masks the hit.
        lu_hit_d     = lookup_i && |(lu_match & ~flush_mask);
        lu_content_d = lu_hit_d ? content_q[lu_idx] : '0;
        if (lu_hit_d) plru_d = plru_touch(plru_d, lu_idx);
        wr_idx = |up_match ? up_idx : !(&valid_q) ? free_idx : plru_victim(plru_q);
        if (update_i && !flush_i) begin
            valid_d[wr_idx]   = 1'b1;
            did_d[wr_idx]     = up_did_i;
            pid_d[wr_idx]     = up_pid_i;
            content_d[wr_idx] = up_content_i;
            plru_d            = plru_touch(plru_d, wr_idx);
        end
        occ_d = '0;
        for (int i = 0; i < ENTRIES; i++) occ_d += OW'(valid_d[i]);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q      <= '0;
            plru_q       <= '0;
            lu_valid_q   <= 1'b0;
            lu_hit_q     <= 1'b0;
            lu_content_q <= '0;
            occ_q        <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                did_q[i]     <= '0;
                pid_q[i]     <= '0;
                content_q[i] <= '0;
            end
        end else begin
            valid_q      <= valid_d;
            did_q        <= did_d;
            pid_q        <= pid_d;
            content_q    <= content_d;
            plru_q       <= plru_d;
            lu_valid_q   <= lu_valid_d;
            lu_hit_q     <= lu_hit_d;
            lu_content_q <= lu_content_d;
            occ_q        <= occ_d;
        end
    end

    assign lu_valid_o   = lu_valid_q;
    assign lu_hit_o     = lu_hit_q;
    assign lu_content_o = lu_content_q;
    assign occ_o        = occ_q;
endmodule

// File: tb/tb_iommu_ctx_cache.sv
// tb_iommu_ctx_cache: table-driven vectors for a 4-entry cache, with lookup results
// checked through an expectation queue, plus reset corner sequences.
module tb_iommu_ctx_cache;
    localparam int CW = 64;

    logic           clk_i = 1'b0;
    logic           rst_ni;
    logic           flush_i, flush_dv_i, flush_pv_i;
    logic [23:0]    flush_did_i;
    logic [19:0]    flush_pid_i;
    logic           update_i;
    logic [23:0]    up_did_i;
    logic [19:0]    up_pid_i;
    logic [CW-1:0]  up_content_i;
    logic           lookup_i;
    logic [23:0]    lu_did_i;
    logic [19:0]    lu_pid_i;
    logic           lu_valid_o, lu_hit_o;
    logic [CW-1:0]  lu_content_o;
    logic [2:0]     occ_o;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic fl, fdv, fpv;
        logic [23:0] fdid;
        logic [19:0] fpid;
        logic up;
        logic [23:0] udid;
        logic [19:0] upid;
        logic [CW-1:0] ucont;
        logic lu;
        logic [23:0] ldid;
        logic [19:0] lpid;
        logic eh;
        logic [CW-1:0] ec;
        logic [2:0] eocc;
    } vec_t;

    typedef struct {
        logic hit;
        logic [CW-1:0] content;
    } sb_t;

    vec_t tv[$];
    sb_t  exp_q[$];
    sb_t  e;

    iommu_ctx_cache #(
        .ENTRIES(4), .DEVICE_ID_WIDTH(24), .PROCESS_ID_WIDTH(20), .PID_EN(1'b1), .CONTENT_WIDTH(CW)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .flush_i(flush_i), .flush_dv_i(flush_dv_i), .flush_pv_i(flush_pv_i),
        .flush_did_i(flush_did_i), .flush_pid_i(flush_pid_i),
        .update_i(update_i), .up_did_i(up_did_i), .up_pid_i(up_pid_i), .up_content_i(up_content_i),
        .lookup_i(lookup_i), .lu_did_i(lu_did_i), .lu_pid_i(lu_pid_i),
        .lu_valid_o(lu_valid_o), .lu_hit_o(lu_hit_o), .lu_content_o(lu_content_o), .occ_o(occ_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [CW-1:0] cv(input int x);
        return 64'hC0DE_0000_0000_0000 | 64'(x);
    endfunction

    function automatic vec_t mk(input logic fl, fdv, fpv, input int fdid, fpid,
                                input logic up, input int udid, upid, input logic [CW-1:0] uc,
                                input logic lu, input int ldid, lpid,
                                input logic eh, input logic [CW-1:0] ec, input int eocc);
        vec_t m;
        m.fl = fl; m.fdv = fdv; m.fpv = fpv; m.fdid = 24'(fdid); m.fpid = 20'(fpid);
        m.up = up; m.udid = 24'(udid); m.upid = 20'(upid); m.ucont = uc;
        m.lu = lu; m.ldid = 24'(ldid); m.lpid = 20'(lpid);
        m.eh = eh; m.ec = ec; m.eocc = 3'(eocc);
        return m;
    endfunction

    function automatic vec_t lk(input int did, pid, input logic eh, input logic [CW-1:0] ec, input int eocc);
        return mk(0, 0, 0, 0, 0, 0, 0, 0, '0, 1, did, pid, eh, ec, eocc);
    endfunction

    function automatic vec_t wr(input int did, pid, input logic [CW-1:0] c, input int eocc);
        return mk(0, 0, 0, 0, 0, 1, did, pid, c, 0, 0, 0, 0, '0, eocc);
    endfunction

    task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        flush_i = 0; flush_dv_i = 0; flush_pv_i = 0; flush_did_i = '0; flush_pid_i = '0;
        update_i = 0; up_did_i = '0; up_pid_i = '0; up_content_i = '0;
        lookup_i = 0; lu_did_i = '0; lu_pid_i = '0;
    endtask

    task automatic apply(input vec_t v, input int n);
        flush_i = v.fl; flush_dv_i = v.fdv; flush_pv_i = v.fpv; flush_did_i = v.fdid; flush_pid_i = v.fpid;
        update_i = v.up; up_did_i = v.udid; up_pid_i = v.upid; up_content_i = v.ucont;
        lookup_i = v.lu; lu_did_i = v.ldid; lu_pid_i = v.lpid;
        if (v.lu) exp_q.push_back('{v.eh, v.ec});
        @(posedge clk_i);
        #1;
        chk($sformatf("occ_v%0d", n), 64'(occ_o), 64'(v.eocc));
        idle();
    endtask

    // Every lookup result is matched against the oldest outstanding expectation.
    always @(negedge clk_i) begin
        if (rst_ni && lu_valid_o) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL lu_unexpected_valid: got lu_valid_o=1 expected no result");
            end else begin
                e = exp_q.pop_front();
                chk("lu_hit", 64'(lu_hit_o), 64'(e.hit));
                chk("lu_content", lu_content_o, e.content);
            end
        end
    end

    initial begin
        idle();
        rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_lu_valid", 64'(lu_valid_o), 64'd0);
        chk("rst_lu_hit", 64'(lu_hit_o), 64'd0);
        chk("rst_lu_content", lu_content_o, 64'd0);
        chk("rst_occ", 64'(occ_o), 64'd0);
        rst_ni = 1'b1;

        tv.push_back(lk(24'h12, 0, 0, '0, 0));
        tv.push_back(wr(1, 0, cv(1), 1));
        tv.push_back(wr(2, 0, cv(2), 2));
        tv.push_back(wr(3, 0, cv(3), 3));
        tv.push_back(mk(0, 0, 0, 0, 0, 1, 4, 0, cv(4), 1, 3, 0, 1, cv(3), 4));
        tv.push_back(lk(1, 0, 1, cv(1), 4));
        tv.push_back(wr(5, 0, cv(5), 4));
        tv.push_back(lk(3, 0, 0, '0, 4));
        tv.push_back(lk(1, 0, 1, cv(1), 4));
        tv.push_back(lk(2, 0, 1, cv(2), 4));
        tv.push_back(lk(4, 0, 1, cv(4), 4));
        tv.push_back(lk(5, 0, 1, cv(5), 4));
        tv.push_back(wr(2, 0, 64'hABAB_ABAB_ABAB_ABAB, 4));
        tv.push_back(lk(2, 0, 1, 64'hABAB_ABAB_ABAB_ABAB, 4));
        tv.push_back(mk(1, 0, 0, 0, 0, 1, 9, 0, cv(9), 1, 4, 0, 0, '0, 0));
        tv.push_back(lk(9, 0, 0, '0, 0));
        tv.push_back(wr(7, 1, cv(32'h71), 1));
        tv.push_back(wr(7, 2, cv(32'h72), 2));
        tv.push_back(wr(8, 1, cv(32'h81), 3));
        tv.push_back(lk(7, 1, 1, cv(32'h71), 3));
        tv.push_back(lk(7, 3, 0, '0, 3));
        tv.push_back(mk(1, 1, 1, 7, 1, 0, 0, 0, '0, 1, 7, 2, 1, cv(32'h72), 2));
        tv.push_back(lk(7, 1, 0, '0, 2));
        tv.push_back(lk(7, 2, 1, cv(32'h72), 2));
        tv.push_back(mk(1, 1, 0, 7, 0, 0, 0, 0, '0, 1, 7, 2, 0, '0, 1));
        tv.push_back(lk(7, 2, 0, '0, 1));
        tv.push_back(lk(8, 1, 1, cv(32'h81), 1));
        tv.push_back(mk(0, 0, 0, 0, 0, 1, 8, 1, cv(32'h99), 1, 8, 1, 1, cv(32'h81), 1));
        tv.push_back(lk(8, 1, 1, cv(32'h99), 1));
        tv.push_back(mk(1, 1, 0, 8, 0, 1, 10, 0, cv(10), 0, 0, 0, 0, '0, 0));
        tv.push_back(lk(10, 0, 0, '0, 0));
        tv.push_back(lk(8, 1, 0, '0, 0));

        foreach (tv[i]) apply(tv[i], i);
        repeat (2) @(posedge clk_i);
        #1;
        chk("lu_missing_results", 64'(exp_q.size()), 64'd0);

        // Reset in the middle of a pending result clears outputs at once.
        apply(wr(3, 0, cv(3), 1), 100);
        lookup_i = 1; lu_did_i = 24'd3;
        @(posedge clk_i);
        #1;
        idle();
        chk("pre_rst_lu_valid", 64'(lu_valid_o), 64'd1);
        chk("pre_rst_lu_content", lu_content_o, cv(3));
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_lu_valid", 64'(lu_valid_o), 64'd0);
        chk("mid_rst_lu_content", lu_content_o, 64'd0);
        chk("mid_rst_occ", 64'(occ_o), 64'd0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        apply(lk(3, 0, 0, '0, 0), 101);
        @(posedge clk_i);
        #1;
        chk("post_rst_results", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/iommu_ctx_cache.md
Name: iommu_ctx_cache

Overview:
Parametrised, fully associative context cache for the IOMMU translation path. It is the successor to the single-key DDTC and serves as both DDTC and PDTC. Entries are tagged by device_id plus an optional process_id. It adds registered (1-cycle) lookup, invalid-first replacement with PLRU fallback, duplicate-free updates, three flush scopes and an occupancy counter. It sits between the context-walk FSM, which issues updates, and the translation front end, which issues lookups. The command queue drives flushes for IODIR.INVAL_DDT and INVAL_PDT.

Parameters:
ENTRIES, 8, number of cache entries; power of 2, at least 2
DEVICE_ID_WIDTH, 24, device_id width; 6, 15 or 24
PROCESS_ID_WIDTH, 20, process_id width
PID_EN, 1, 1 = process_id is part of the tag; 0 = process_id is ignored everywhere
CONTENT_WIDTH, 512, width of the cached context

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous reset, active low
flush_i  in  1  flush request
flush_dv_i  in  1  device_id valid: 0 = flush all entries
flush_pv_i  in  1  process_id valid: meaningful only when flush_dv_i=1 and PID_EN=1
flush_did_i  in  DEVICE_ID_WIDTH  device_id to flush
flush_pid_i  in  PROCESS_ID_WIDTH  process_id to flush
update_i  in  1  write request
up_did_i  in  DEVICE_ID_WIDTH  device_id to write
up_pid_i  in  PROCESS_ID_WIDTH  process_id to write
up_content_i  in  CONTENT_WIDTH  context to write
lookup_i  in  1  lookup request
lu_did_i  in  DEVICE_ID_WIDTH  device_id to look up
lu_pid_i  in  PROCESS_ID_WIDTH  process_id to look up
lu_valid_o  out  1  lookup result valid (one cycle after lookup_i)
lu_hit_o  out  1  hit flag, qualified by lu_valid_o
lu_content_o  out  CONTENT_WIDTH  hit content; zero on a miss
occ_o  out  $clog2(ENTRIES)+1  number of valid entries

Behaviour:
- Reset (asynchronous): all valid bits 0, content 0, PLRU tree 0, lu_valid_o=0, lu_hit_o=0, lu_content_o=0, occ_o=0.
- Tag match: valid, device_id equal, and (PID_EN=0 or process_id equal).
- Lookup:
  - Compared against registered state in cycle N; result registered and presented in cycle N+1.
  - lu_valid_o is high for exactly one cycle per lookup_i. Back-to-back lookups are allowed, one result per cycle.
  - No bypass: an update in cycle N is not visible to a lookup in cycle N.
  - A lookup in cycle N whose matched entry is flushed in cycle N reports lu_hit_o=0 in N+1.
- Update (takes effect at the next edge):
  - If the key already matches entry k, overwrite k's content. No duplicates are created and occ_o is unchanged.
  - Otherwise, if any entry is invalid, write the lowest-index invalid entry and increment occ_o.
  - Otherwise, write the PLRU victim.
- Flush, with priority over update in the same cycle (the update is dropped):
  - dv=0: invalidate all entries.
  - dv=1, pv=0 (or PID_EN=0): invalidate every entry whose device_id matches.
  - dv=1, pv=1: invalidate the entry matching both device_id and process_id.
  - A lookup in the same cycle is still served against pre-flush tags, except for the masking rule above.
- occ_o: registered popcount of the valid bits. It equals the count at the end of the previous cycle and never exceeds ENTRIES.
- PLRU: binary tree with ENTRIES-1 nodes, root at node 0, children of node n at 2n+1 and 2n+2.
  - A node bit of 0 means the victim lies in the left subtree.
  - Touching entry i (a lookup hit, or an update write) sets every node on i's path to point away from i.
  - Victim = entry reached by following the node pointers from the root.
  - A lookup hit and an update write in the same cycle: apply the lookup touch first, then the update touch.
  - Flushes do not modify the tree.
- Concurrency: lookup, update and flush may all be asserted in the same cycle. Apply flush, then update; the lookup is evaluated on pre-edge state.
- Reset asserted mid-operation: a pending lookup result is discarded; lu_valid_o=0 immediately.

Test Plan:
- ENTRIES=4. Reset, then lookup did=0x12 -> next cycle lu_valid_o=1, lu_hit_o=0, lu_content_o=0, occ_o=0.
- Update keys A..D (did 1..4, pid 0) on consecutive cycles -> written to entries 0..3; occ_o reaches 4. Lookup did=3 -> hit with D3 content in 1 cycle.
- After the previous step: lookup A (entry 0), then update E (did=5) -> E replaces entry 2 (C). Lookup did=3 misses; lookups of did 1, 2, 4 and 5 hit.
- PID_EN=1: insert (did 7, pid 1) and (did 7, pid 2), then flush dv=1, pv=1, pid=1 -> only (7,1) misses; occ_o drops by 1. Flush dv=1, pv=0, did=7 -> both miss.
- Same cycle: flush dv=0, update did=9, lookup of a valid key -> that lookup reports lu_hit_o=0; did=9 is not cached; occ_o=0.
- Update an existing key did=2 with new content 0xAB.. -> occ_o unchanged; next lookup returns the new content.
